// File: rtl/lcd_panel_pkg.sv
// Shared opcodes, controller state encoding and read-ID byte selection
// for the 8080-style LCD panel emulator.
`default_nettype none

package lcd_panel_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_RDID    = 8'h04;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_TEOFF   = 8'h34;
  localparam logic [7:0] CMD_TEON    = 8'h35;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_PASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_RDID  = 3'd4
  } state_t;

  // Index 0 is the dummy read cycle; anything past the three ID bytes reads 0.
  function automatic logic [7:0] rdid_byte(input logic [2:0] idx, input logic [23:0] id);
    case (idx)
      3'd1:    return id[23:16];
      3'd2:    return id[15:8];
      3'd3:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_fmark_gen.sv
// Free-running frame counter producing the tearing-effect (FMARK) pulse
// at the start of every frame while tearing output is enabled.
`default_nettype none

module lcd_fmark_gen #(
  parameter int FMARK_PERIOD = 833333,
  parameter int FMARK_LEN    = 64
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_te_set,
  input  logic i_te_clr,
  output logic o_fmark
);

  localparam int CW = (FMARK_PERIOD > 1) ? $clog2(FMARK_PERIOD) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_te_en;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_te_en <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == CW'(FMARK_PERIOD - 1)) ? '0 : r_cnt + CW'(1);
      if (i_te_set)
        r_te_en <= 1'b1;
      else if (i_te_clr)
        r_te_en <= 1'b0;
    end
  end

  assign o_fmark = r_te_en & (32'(r_cnt) < 32'(FMARK_LEN));

endmodule

`default_nettype wire

// File: rtl/lcd_panel_emu.sv
// Emulates an 18-bit 8080-bus TFT controller: decodes window/RAM-write/ID
// commands and turns pixel writes into framebuffer write strobes.
`default_nettype none

module lcd_panel_emu
  import lcd_panel_pkg::*;
#(
  parameter int          WIDTH        = 480,
  parameter int          HEIGHT       = 320,
  parameter int          FMARK_PERIOD = 833333,
  parameter int          FMARK_LEN    = 64,
  parameter logic [23:0] ID_VAL       = 24'h009341
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [17:0]                         lcd_db_in,
  output logic [17:0]                         lcd_db_out,
  output logic                                lcd_db_oe,
  input  logic                                lcd_rs,
  input  logic                                lcd_wr,
  input  logic                                lcd_rd,
  input  logic                                lcd_cs,
  input  logic                                lcd_rst,
  output logic                                lcd_fmark,
  output logic                                lcd_id,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     fb_addr,
  output logic [15:0]                         fb_data,
  output logic                                fb_we
);

  localparam int AW = $clog2(WIDTH * HEIGHT);

  // Bus input synchroniser stage plus previous-cycle copies for edge detection.
  logic [15:0] r_db;
  logic        r_rs, r_wr, r_rd, r_cs, r_rst_n, r_wr_d, r_rd_d;
  logic        r_was_rst;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_db    <= '0;
      r_rs    <= 1'b0;
      r_wr    <= 1'b1;
      r_rd    <= 1'b1;
      r_cs    <= 1'b1;
      r_rst_n <= 1'b0;
      r_wr_d  <= 1'b1;
      r_rd_d  <= 1'b1;
    end else begin
      r_db    <= lcd_db_in[15:0];
      r_rs    <= lcd_rs;
      r_wr    <= lcd_wr;
      r_rd    <= lcd_rd;
      r_cs    <= lcd_cs;
      r_rst_n <= lcd_rst;
      r_wr_d  <= r_wr;
      r_rd_d  <= r_rd;
    end
  end

  logic       w_rst, w_wr_evt, w_rd_evt, w_cmd, w_dat, w_soft;
  logic [7:0] w_op;

  assign w_rst    = ~nrst | ~r_rst_n;
  assign w_op     = r_db[7:0];
  assign w_wr_evt = r_wr & ~r_wr_d & ~r_cs & r_rd & ~w_rst & ~r_was_rst;
  assign w_rd_evt = ~r_rd & r_rd_d & ~r_cs & r_wr & ~w_rst;
  assign w_cmd    = w_wr_evt & ~r_rs;
  assign w_dat    = w_wr_evt & r_rs;
  assign w_soft   = w_cmd & (w_op == CMD_SWRESET);

  // A write edge landing in the first cycle out of reset is not trusted.
  always_ff @(posedge clk) r_was_rst <= w_rst;

  state_t r_state, w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd) begin
      case (w_op)
        CMD_CASET:             w_state_nxt = ST_CASET;
        CMD_PASET:             w_state_nxt = ST_PASET;
        CMD_RAMWR, CMD_RAMWRC: w_state_nxt = ST_RAMWR;
        CMD_RDID:              w_state_nxt = ST_RDID;
        default:               w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  logic [15:0] r_sc, r_ec, r_sp, r_ep, r_col, r_row;
  logic [2:0]  r_pidx;
  logic        w_in_win, w_col_end, w_row_end;
  logic [31:0] w_lin;

  assign w_in_win  = (r_col < 16'(WIDTH)) && (r_row < 16'(HEIGHT));
  assign w_col_end = (r_col == r_ec) || (r_col == 16'(WIDTH - 1));
  assign w_row_end = (r_row == r_ep) || (r_row == 16'(HEIGHT - 1));
  assign w_lin     = 32'(r_row) * 32'(WIDTH) + 32'(r_col);

  always_ff @(posedge clk) begin
    if (w_rst || w_soft) begin
      r_sc   <= '0;
      r_ec   <= 16'(WIDTH - 1);
      r_sp   <= '0;
      r_ep   <= 16'(HEIGHT - 1);
      r_col  <= '0;
      r_row  <= '0;
      r_pidx <= '0;
    end else if (w_cmd) begin
      r_pidx <= '0;
      if (w_op == CMD_RAMWR) begin
        r_col <= r_sc;
        r_row <= r_sp;
      end
    end else if (w_dat) begin
      case (r_state)
        ST_CASET, ST_PASET: begin
          if (r_pidx < 3'd4) begin
            r_pidx <= r_pidx + 3'd1;
            if (r_state == ST_CASET) begin
              case (r_pidx[1:0])
                2'd0:    r_sc[15:8] <= w_op;
                2'd1:    r_sc[7:0]  <= w_op;
                2'd2:    r_ec[15:8] <= w_op;
                default: r_ec[7:0]  <= w_op;
              endcase
            end else begin
              case (r_pidx[1:0])
                2'd0:    r_sp[15:8] <= w_op;
                2'd1:    r_sp[7:0]  <= w_op;
                2'd2:    r_ep[15:8] <= w_op;
                default: r_ep[7:0]  <= w_op;
              endcase
            end
          end
        end
        ST_RAMWR: begin
          // Out-of-window pixels are dropped but still move the pointer.
          if (w_col_end) begin
            r_col <= r_sc;
            r_row <= w_row_end ? r_sp : r_row + 16'd1;
          end else begin
            r_col <= r_col + 16'd1;
          end
        end
        default: ;
      endcase
    end else if (w_rd_evt && (r_state == ST_RDID) && (r_pidx < 3'd4)) begin
      r_pidx <= r_pidx + 3'd1;
    end
  end

  logic [7:0] r_db_out;

  always_ff @(posedge clk) begin
    if (w_rst)
      r_db_out <= '0;
    else if (w_rd_evt)
      r_db_out <= (r_state == ST_RDID) ? rdid_byte(r_pidx, ID_VAL) : 8'h00;
  end

  // Two-stage pixel path: capture at the write event, strobe one cycle later.
  logic          r_px_vld, r_fb_we;
  logic [AW-1:0] r_px_addr, r_fb_addr;
  logic [15:0]   r_px_data, r_fb_data;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_px_vld  <= 1'b0;
      r_px_addr <= '0;
      r_px_data <= '0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_px_vld <= w_dat && (r_state == ST_RAMWR) && w_in_win;
      if (w_dat) begin
        r_px_addr <= w_lin[AW-1:0];
        r_px_data <= r_db;
      end
      r_fb_we <= r_px_vld;
      if (r_px_vld) begin
        r_fb_addr <= r_px_addr;
        r_fb_data <= r_px_data;
      end
    end
  end

  lcd_fmark_gen #(
    .FMARK_PERIOD (FMARK_PERIOD),
    .FMARK_LEN    (FMARK_LEN)
  ) u_fmark (
    .clk      (clk),
    .i_rst    (w_rst),
    .i_te_set (w_cmd & (w_op == CMD_TEON)),
    .i_te_clr (w_cmd & ((w_op == CMD_TEOFF) | (w_op == CMD_SWRESET))),
    .o_fmark  (lcd_fmark)
  );

  logic w_unused;
  assign w_unused = ^{lcd_db_in[17:16], w_lin[31:AW]};

  assign lcd_db_out = {10'd0, r_db_out};
  assign lcd_db_oe  = ~r_rd & ~r_cs & ~w_rst;
  assign lcd_id     = 1'b1;
  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_panel_emu.sv
// Scoreboard bench for lcd_panel_emu: directed scenarios then random bus traffic
// compared against a behavioural panel model.
`default_nettype none

module tb_lcd_panel_emu;

  localparam int          W  = 480;
  localparam int          H  = 320;
  localparam int          FP = 100;
  localparam int          FL = 4;
  localparam logic [23:0] ID = 24'h009341;
  localparam int          AW = $clog2(W * H);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [17:0]   db_in = '0;
  logic          rs = 1'b0, wr = 1'b1, rd = 1'b1, cs = 1'b1, lrst = 1'b1;
  logic [17:0]   db_out;
  logic          db_oe, fmark, id_pin, fb_we;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data;

  lcd_panel_emu #(
    .WIDTH(W), .HEIGHT(H), .FMARK_PERIOD(FP), .FMARK_LEN(FL), .ID_VAL(ID)
  ) dut (
    .clk(clk), .nrst(nrst), .lcd_db_in(db_in), .lcd_db_out(db_out), .lcd_db_oe(db_oe),
    .lcd_rs(rs), .lcd_wr(wr), .lcd_rd(rd), .lcd_cs(cs), .lcd_rst(lrst),
    .lcd_fmark(fmark), .lcd_id(id_pin), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } px_t;
  px_t        px_q[$];
  logic [7:0] rd_q[$];

  // Behavioural panel model: mode 0 idle, 1 column set, 2 page set, 3 RAM write, 4 ID read.
  int          m_mode, m_pidx, m_ridx;
  logic [15:0] m_sc, m_ec, m_sp, m_ep, m_col, m_row;

  task automatic m_reset();
    m_mode = 0; m_pidx = 0; m_ridx = 0;
    m_sc = 0; m_sp = 0; m_ec = 16'(W - 1); m_ep = 16'(H - 1);
    m_col = 0; m_row = 0;
  endtask

  task automatic m_cmd(input logic [7:0] c);
    m_pidx = 0;
    case (c)
      8'h2A: m_mode = 1;
      8'h2B: m_mode = 2;
      8'h2C: begin m_mode = 3; m_col = m_sc; m_row = m_sp; end
      8'h3C: m_mode = 3;
      8'h04: begin m_mode = 4; m_ridx = 0; end
      8'h01: m_reset();
      default: m_mode = 0;
    endcase
  endtask

  task automatic m_data(input logic [17:0] d);
    px_t p;
    if (m_mode == 1 || m_mode == 2) begin
      if (m_pidx < 4) begin
        if (m_mode == 1) begin
          if (m_pidx == 0) m_sc[15:8] = d[7:0];
          if (m_pidx == 1) m_sc[7:0]  = d[7:0];
          if (m_pidx == 2) m_ec[15:8] = d[7:0];
          if (m_pidx == 3) m_ec[7:0]  = d[7:0];
        end else begin
          if (m_pidx == 0) m_sp[15:8] = d[7:0];
          if (m_pidx == 1) m_sp[7:0]  = d[7:0];
          if (m_pidx == 2) m_ep[15:8] = d[7:0];
          if (m_pidx == 3) m_ep[7:0]  = d[7:0];
        end
        m_pidx++;
      end
    end else if (m_mode == 3) begin
      if (int'(m_col) < W && int'(m_row) < H) begin
        p.addr = AW'(int'(m_row) * W + int'(m_col));
        p.data = d[15:0];
        px_q.push_back(p);
      end
      if (m_col == m_ec || int'(m_col) == W - 1) begin
        m_col = m_sc;
        if (m_row == m_ep || int'(m_row) == H - 1) m_row = m_sp;
        else m_row = m_row + 16'd1;
      end else begin
        m_col = m_col + 16'd1;
      end
    end
  endtask

  task automatic bus_write(input logic rsv, input logic [17:0] d, input logic csv);
    if (!csv) begin
      if (rsv) m_data(d);
      else     m_cmd(d[7:0]);
    end
    @(negedge clk);
    cs = csv; rs = rsv; db_in = d; wr = 1'b0;
    repeat (2) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1;
  endtask

  task automatic cmd(input logic [7:0] c);
    bus_write(1'b0, {10'($urandom), c}, 1'b0);
  endtask

  task automatic dat(input logic [17:0] d);
    bus_write(1'b1, d, 1'b0);
  endtask

  task automatic set_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    cmd(c);
    dat({10'($urandom), s[15:8]});
    dat({10'($urandom), s[7:0]});
    dat({10'($urandom), e[15:8]});
    dat({10'($urandom), e[7:0]});
  endtask

  task automatic bus_read();
    logic [7:0] exp;
    exp = 8'h00;
    if (m_mode == 4) begin
      case (m_ridx)
        1: exp = ID[23:16];
        2: exp = ID[15:8];
        3: exp = ID[7:0];
        default: exp = 8'h00;
      endcase
      m_ridx++;
    end
    rd_q.push_back(exp);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    check("oe_during_read", 32'(db_oe), 32'd1);
    rd = 1'b1;
    repeat (2) @(negedge clk);
    check("oe_after_read", 32'(db_oe), 32'd0);
    cs = 1'b1;
  endtask

  task automatic panel_reset();
    repeat (4) @(negedge clk);
    lrst = 1'b0;
    repeat (3) @(negedge clk);
    lrst = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic fmark_test(input bit on);
    int hi, last_rise;
    logic prev;
    hi = 0; last_rise = -1; prev = fmark;
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      if (fmark) hi++;
      if (fmark && !prev) begin
        if (last_rise >= 0) check("fmark_period", 32'(i - last_rise), 32'(FP));
        last_rise = i;
      end
      prev = fmark;
    end
    check(on ? "fmark_on_high" : "fmark_off_high", 32'(hi), on ? 32'(3 * FL) : 32'd0);
  endtask

  // Framebuffer monitor: every strobe must match the oldest expected pixel.
  always @(negedge clk) begin
    if (fb_we) begin
      if (px_q.size() == 0) begin
        check("fb_unexpected_we", 32'(fb_addr), 32'hFFFF_FFFF);
      end else begin
        px_t p;
        p = px_q.pop_front();
        check("fb_addr", 32'(fb_addr), 32'(p.addr));
        check("fb_data", 32'(fb_data), 32'(p.data));
      end
    end
  end

  // Read monitor: compare the bus value seen just before the panel releases it.
  logic        mon_prev_oe = 1'b0;
  logic [17:0] mon_last = '0;
  always @(negedge clk) begin
    if (mon_prev_oe && !db_oe) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'(mon_last), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        check("rd_data", 32'(mon_last), 32'({10'd0, e}));
      end
    end
    if (db_oe) mon_last = db_out;
    mon_prev_oe = db_oe;
  end

  initial begin
    int r, n;
    logic [15:0] s, e;
    m_reset();
    repeat (4) @(negedge clk);
    check("rst_db_out", 32'(db_out), 32'd0);
    check("rst_db_oe",  32'(db_oe),  32'd0);
    check("rst_fmark",  32'(fmark),  32'd0);
    check("rst_fb_we",  32'(fb_we),  32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_lcd_id", 32'(id_pin), 32'd1);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    cmd(8'h2C); dat(18'h0F800); dat(18'h007E0);

    set_win(8'h2A, 16'd10, 16'd11);
    set_win(8'h2B, 16'd5, 16'd6);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) dat(18'(16'h1000 + i));

    cmd(8'h04);
    for (int i = 0; i < 5; i++) bus_read();

    cmd(8'h35); fmark_test(1'b1);
    cmd(8'h34); fmark_test(1'b0);

    cmd(8'h2C); dat(18'h0AAAA);
    bus_write(1'b1, 18'h05555, 1'b1);
    bus_write(1'b0, 18'h00004, 1'b1);
    dat(18'h01234);
    panel_reset();
    dat(18'h0BEEF);
    cmd(8'h2C); dat(18'h0C0DE);

    set_win(8'h2A, 16'd479, 16'd479);
    cmd(8'h2C); dat(18'h00001); dat(18'h00002);
    set_win(8'h2A, 16'd500, 16'd501);
    cmd(8'h2C); dat(18'h00003); dat(18'h00004);
    bus_read();

    cmd(8'h01); cmd(8'h3C); dat(18'h0FACE);

    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10 || (r >= 10 && r < 20)) begin
        n = (r < 10) ? W : H;
        s = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(n - 8, n + 15))
                                         : 16'($urandom_range(0, n - 1));
        e = s + 16'($urandom_range(0, 3));
        set_win((r < 10) ? 8'h2A : 8'h2B, s, e);
        if ($urandom_range(0, 3) == 0) dat(18'($urandom));
      end else if (r < 30) cmd(8'h2C);
      else if (r < 35) cmd(8'h3C);
      else if (r < 70) dat(18'($urandom));
      else if (r < 75) bus_write(1'b1, 18'($urandom), 1'b1);
      else if (r < 82) begin
        cmd(8'h04);
        n = int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) bus_read();
      end else if (r < 85) bus_read();
      else if (r < 88) begin
        case ($urandom_range(0, 3))
          0: cmd(8'h00);
          1: cmd(8'h11);
          2: cmd(8'h29);
          default: cmd(8'h01);
        endcase
      end else if (r < 90) panel_reset();
      else dat(18'($urandom));
    end

    repeat (10) @(negedge clk);
    check("px_queue_drained", 32'(px_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/lcd_panel_emu.md
LCD_PANEL_EMU -- requirements
Module: lcd_panel_emu

Interface
REQ-001 Parameter WIDTH, 480, panel columns.
REQ-002 Parameter HEIGHT, 320, panel rows.
REQ-003 Parameter FMARK_PERIOD, 833333, clk cycles per FMARK frame.
REQ-004 Parameter FMARK_LEN, 64, FMARK high time in clk cycles.
REQ-005 Parameter ID_VAL, 24'h009341, value returned by read-ID.
REQ-006 clk  in  1  clock; nrst  in  1  reset, synchronous, active-low.
REQ-007 lcd_db_in  in  18  host-driven data bus; lcd_db_out  out  18  panel read data; lcd_db_oe  out  1  panel drives bus.
REQ-008 lcd_rs  in  1  0 command, 1 data; lcd_wr  in  1  write strobe, active-low; lcd_rd  in  1  read strobe, active-low.
REQ-009 lcd_cs  in  1  chip select, active-low; lcd_rst  in  1  panel reset, active-low.
REQ-010 lcd_fmark  out  1  tearing-effect pulse; lcd_id  out  1  constant 1.
REQ-011 fb_addr  out  clog2(WIDTH*HEIGHT)  pixel index; fb_data  out  16  RGB565; fb_we  out  1  one-cycle write strobe.

Function
REQ-012 All lcd_* inputs registered once on clk; all edge detection uses the registered copies and their previous-cycle values.
REQ-013 Write event: registered lcd_wr rises 0->1 while registered lcd_cs = 0; captured value = registered lcd_db_in at that cycle.
REQ-014 Read event: registered lcd_rd falls 1->0 while lcd_cs = 0; lcd_db_out loads next read value that cycle; lcd_db_oe = 1 while registered rd = 0 and cs = 0, else 0.
REQ-015 Bus events with lcd_cs = 1 are ignored; lcd_wr and lcd_rd both low are ignored.
REQ-016 Command write (rs = 0) loads cmd = db[7:0], clears parameter index; FSM states IDLE, CASET, PASET, RAMWR, RDID.
REQ-017 0x2A -> CASET: params 0..3 = SC[15:8], SC[7:0], EC[15:8], EC[7:0] from db[7:0]; 5th and later params ignored.
REQ-018 0x2B -> PASET: same layout for SP/EP.
REQ-019 0x2C -> RAMWR, pointer (col,row) = (SC,SP); 0x3C -> RAMWR, pointer unchanged.
REQ-020 RAMWR data write: fb_we = 1 two clks after the write-event cycle, fb_addr = row*WIDTH+col, fb_data = db[15:0]; then col++.
REQ-021 Wrap: col = EC or col = WIDTH-1 -> col = SC, row++; row = EP or row = HEIGHT-1 at that wrap -> row = SP.
REQ-022 Pointer with col >= WIDTH or row >= HEIGHT: fb_we suppressed, pointer still advances.
REQ-023 0x04 -> RDID; reads return 0x00 (dummy), ID_VAL[23:16], [15:8], [7:0], then 0x00 thereafter.
REQ-024 0x35 sets te_en, 0x34 clears it; lcd_fmark = te_en and frame counter < FMARK_LEN.
REQ-025 Frame counter free-runs 0..FMARK_PERIOD-1, wraps to 0.
REQ-026 0x01 (soft reset) equals REQ-028 state except frame counter keeps running.
REQ-027 Other commands -> IDLE; data writes in IDLE ignored; reads outside RDID return 0.

Reset
REQ-028 nrst = 0 or registered lcd_rst = 0: FSM IDLE, SC = SP = 0, EC = WIDTH-1, EP = HEIGHT-1, pointer (0,0), te_en = 0, frame counter 0.
REQ-029 Outputs in reset: lcd_db_out = 0, lcd_db_oe = 0, lcd_fmark = 0, fb_we = 0, fb_addr = 0, fb_data = 0; lcd_id = 1.
REQ-030 A write event in the cycle reset deasserts is dropped; transaction mid-flight at reset assertion is abandoned with no fb_we.

Structure
REQ-031 Package lcd_panel_pkg holds command opcodes (0x01, 0x04, 0x2A, 0x2B, 0x2C, 0x34, 0x35, 0x3C) and the FSM state enum.
REQ-032 Sub-module lcd_fmark_gen (frame counter, te_en gate, FMARK output); all else in lcd_panel_emu.

Verification
REQ-033 Reset then cmd 0x2C, data 0xF800, 0x07E0 -> fb_we at addr 0 data 0xF800, addr 1 data 0x07E0.
REQ-034 CASET 0,10,0,11; PASET 0,5,0,6; 0x2C; 5 data writes -> addrs 2410, 2411, 2890, 2891, 2410.
REQ-035 Cmd 0x04, 4 reads -> lcd_db_out 0x00, 0x00, 0x93, 0x41; lcd_db_oe high only while rd low.
REQ-036 FMARK_PERIOD = 100, FMARK_LEN = 4: cmd 0x35 -> fmark high 4 of every 100 clks; cmd 0x34 -> fmark stays 0.
REQ-037 Pulse wr with cs = 1 -> no state change; lcd_rst low mid-RAMWR -> pointer (0,0), next data in IDLE ignored.
REQ-038 CASET SC = EC = 479, 0x2C, 2 writes -> addrs 479, 959; CASET SC = 500 -> fb_we suppressed.
